// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave wait-request bus arbiter with stall timeout abort.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break (default: master 0 wins).
module mips_bus_arbiter #(
    parameter int MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        bus_error
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last_grant, last_nx;
    logic          err_nx;
    logic          req0, req1;
    logic          sel, req_sel;
    logic          abort;
    logic          pick1;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign sel     = (state == GRANT1);
    assign req_sel = sel ? req1 : req0;
    assign abort   = (state != IDLE) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_nx;
            bus_error  <= err_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        last_nx        = last_grant;
        err_nx         = bus_error;
        pick1          = 1'b0;
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        grant          = 2'b00;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick1 = req1 && (!req0 || !last_grant);
`else
                    pick1 = !req0;
`endif
                    state_nx = pick1 ? GRANT1 : GRANT0;
                    last_nx  = pick1;
                    cnt_nx   = '0;
                end
            end
            GRANT0, GRANT1: begin
                grant        = sel ? 2'b10 : 2'b01;
                s_address    = sel ? m1_address : m0_address;
                s_writedata  = sel ? m1_writedata : m0_writedata;
                s_byteenable = sel ? m1_byteenable : m0_byteenable;
                s_read       = !abort && (sel ? m1_read : m0_read);
                s_write      = !abort && (sel ? m1_write : m0_write);
                // Abort releases the master with zero data.
                if (sel) begin
                    m1_waitrequest = s_waitrequest && !abort;
                    m1_readdata    = abort ? '0 : s_readdata;
                end else begin
                    m0_waitrequest = s_waitrequest && !abort;
                    m0_readdata    = abort ? '0 : s_readdata;
                end
                if (abort) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (!req_sel || !s_waitrequest) begin
                    state_nx = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mips_bus_arbiter;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_read, m0_write, m0_waitrequest;
    logic [3:0]  m0_byteenable;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_read, m1_write, m1_waitrequest;
    logic [3:0]  m1_byteenable;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic [3:0]  s_byteenable;
    logic        s_read, s_write, s_waitrequest;
    logic [1:0]  grant;
    logic        bus_error;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .bus_error(bus_error)
    );

    // {grant, m0_wait, m1_wait, s_read, s_write, bus_error}
    function automatic logic [6:0] ctl();
        return {grant, m0_waitrequest, m1_waitrequest, s_read, s_write, bus_error};
    endfunction

    function automatic logic [138:0] outs();
        return {grant, bus_error, s_address, s_writedata, s_byteenable, s_read,
                s_write, m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata};
    endfunction

    task automatic idle_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        logic [6:0] rst_ctl;
        rst_ctl = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        idle_inputs();
        reset = 0;
        m0_read = 1; m0_address = 32'h4;
        m1_read = 1; m1_address = 32'h8;
        s_readdata = 32'h55;
        #2;
        vecs++;
        if ({ctl(), s_address, m0_readdata, m1_readdata} !== {rst_ctl, 96'h0}) begin
            errs++;
            $display("FAIL reset_hold got %b/%h exp %b/0", ctl(), s_address, rst_ctl);
        end
        @(posedge clk); #1;
        vecs++;
        if (ctl() !== rst_ctl) begin
            errs++;
            $display("FAIL reset_edge got %b exp %b", ctl(), rst_ctl);
        end
        @(negedge clk); #2;
        reset = 1;
        @(posedge clk); #1;
        vecs++;
        if (grant !== 2'b01) begin
            errs++;
            $display("FAIL reset_release_grant got %b exp 01", grant);
        end
        #2;
        reset = 0;
        #1;
        vecs++;
        if ({ctl(), s_address, m0_readdata} !== {rst_ctl, 64'h0}) begin
            errs++;
            $display("FAIL reset_async got %b/%h exp %b/0", ctl(), s_address, rst_ctl);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        m0_read = 1; m0_address = 32'h10;
        s_readdata = 32'hCAFEF00D; s_waitrequest = 0;
        @(negedge clk);
        vecs++;
        if (ctl() !== {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL read_arb got %b exp 0011000", ctl());
        end
        @(negedge clk);
        vecs++;
        if ({ctl(), s_address, m0_readdata, m1_readdata} !==
            {2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0}) begin
            errs++;
            $display("FAIL read_grant got %b %h %h %h exp 0101100 10 cafef00d 0",
                     ctl(), s_address, m0_readdata, m1_readdata);
        end
        @(posedge clk); #1;
        m0_read = 0;
        @(negedge clk);
        vecs++;
        if (grant !== 2'b00) begin
            errs++;
            $display("FAIL read_done got %b exp 00", grant);
        end
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        do_reset();
        @(posedge clk); #1;
        m0_write = 1; m0_address = 32'h20; m0_writedata = 32'h12345678; m0_byteenable = 4'b0011;
        m1_read = 1; m1_address = 32'h40;
        s_waitrequest = 0; s_readdata = 32'h77;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if ({ctl(), s_address, s_writedata, s_byteenable} !==
            {2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 4'b0011}) begin
            errs++;
            $display("FAIL cont_m0 got %b %h %h %b", ctl(), s_address, s_writedata, s_byteenable);
        end
        @(posedge clk); #1;
        m0_write = 0;
        @(negedge clk);
        vecs++;
        if (ctl() !== {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL cont_idle got %b exp 0011000", ctl());
        end
        @(negedge clk);
        vecs++;
        if ({ctl(), s_address, m1_readdata} !==
            {2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h77}) begin
            errs++;
            $display("FAIL cont_m1 got %b %h %h", ctl(), s_address, m1_readdata);
        end
        @(posedge clk); #1;
        m1_read = 0;
        do_reset();
        @(posedge clk); #1;
        m0_read = 1; m1_read = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            eg = 2'b00;
            if (i % 2 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                eg = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
`else
                eg = 2'b01;
`endif
            end
            vecs++;
            if (grant !== eg) begin
                errs++;
                $display("FAIL cont_seq%0d got %b exp %b", i, grant, eg);
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        @(posedge clk); #1;
        m1_read = 1; m1_address = 32'h80;
        s_waitrequest = 1; s_readdata = 32'h1111;
        @(posedge clk); #1;
        m0_read = 1; m0_address = 32'h90;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if ({ctl(), s_address} !== {2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80}) begin
                errs++;
                $display("FAIL stall%0d got %b %h exp 1011100 80", i, ctl(), s_address);
            end
            @(posedge clk);
        end
        #1;
        s_waitrequest = 0; s_readdata = 32'hBEEF0001;
        @(negedge clk);
        vecs++;
        if ({ctl(), m1_readdata, m0_readdata} !==
            {2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBEEF0001, 32'h0}) begin
            errs++;
            $display("FAIL stall_done got %b %h %h", ctl(), m1_readdata, m0_readdata);
        end
        @(posedge clk); #1;
        m1_read = 0;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (grant !== 2'b01) begin
            errs++;
            $display("FAIL stall_m0_next got %b exp 01", grant);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        @(posedge clk); #1;
        m0_read = 1; m0_address = 32'h100;
        s_waitrequest = 1; s_readdata = 32'hDEADBEEF;
        @(negedge clk);
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            vecs++;
            if (ctl() !== {2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errs++;
                $display("FAIL to_stall%0d got %b exp 0111100", i, ctl());
            end
        end
        @(negedge clk);
        vecs++;
        if ({ctl(), m0_readdata} !== {2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL to_abort got %b %h exp 0101000 0", ctl(), m0_readdata);
        end
        @(posedge clk); #1;
        m0_read = 0; s_waitrequest = 0;
        @(negedge clk);
        vecs++;
        if ({grant, bus_error} !== 3'b001) begin
            errs++;
            $display("FAIL to_err got %b exp 001", {grant, bus_error});
        end
        @(posedge clk); #1;
        m1_write = 1; m1_address = 32'h44; m1_writedata = 32'hA5A5;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (ctl() !== {2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errs++;
            $display("FAIL to_sticky got %b exp 1010011", ctl());
        end
        @(posedge clk); #1;
        m1_write = 0;
        @(negedge clk);
        vecs++;
        if ({grant, bus_error} !== 3'b001) begin
            errs++;
            $display("FAIL to_sticky_idle got %b exp 001", {grant, bus_error});
        end
    endtask

    task automatic test_random();
        logic [31:0] a_addr[2], a_data[2];
        logic [3:0]  a_be[2];
        logic        a_rd[2], a_wr[2];
        bit          busy[2], done[2];
        int          owner, stalls, last, stuck, n, pick;
        bit          ab, err;
        logic [1:0]  e_grant;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
        logic [3:0]  e_be;
        logic        e_r, e_w, e_w0, e_w1;
        logic [138:0] exp_v;
        do_reset();
        owner = 0; stalls = 0; last = 1; err = 0; stuck = 0;
        for (int k = 0; k < 2; k++) begin
            a_addr[k] = '0; a_data[k] = '0; a_be[k] = '0;
            a_rd[k] = 0; a_wr[k] = 0; busy[k] = 0; done[k] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (done[k]) begin
                    busy[k] = 0; done[k] = 0; a_rd[k] = 0; a_wr[k] = 0;
                end else if (!busy[k] && $urandom_range(0, 2) == 0) begin
                    busy[k] = 1;
                    a_rd[k] = $urandom_range(0, 1);
                    a_wr[k] = !a_rd[k];
                    a_addr[k] = $urandom; a_data[k] = $urandom;
                    a_be[k] = 4'($urandom_range(0, 15));
                end
            end
            if (stuck > 0) begin
                s_waitrequest = 1; stuck--;
            end else begin
                s_waitrequest = ($urandom_range(0, 99) < 55);
                if ($urandom_range(0, 149) == 0) stuck = MW + 2;
            end
            s_readdata = $urandom;
            m0_address = a_addr[0]; m0_writedata = a_data[0]; m0_byteenable = a_be[0];
            m0_read = a_rd[0]; m0_write = a_wr[0];
            m1_address = a_addr[1]; m1_writedata = a_data[1]; m1_byteenable = a_be[1];
            m1_read = a_rd[1]; m1_write = a_wr[1];
            @(negedge clk);
            e_grant = 2'b00; e_addr = '0; e_wdata = '0; e_be = '0; e_r = 0; e_w = 0;
            e_w0 = 1; e_w1 = 1; e_rd0 = '0; e_rd1 = '0; ab = 0; n = 0;
            if (owner != 0) begin
                n = owner - 1;
                ab = (stalls == MW);
                e_grant = (n == 0) ? 2'b01 : 2'b10;
                e_addr = a_addr[n]; e_wdata = a_data[n]; e_be = a_be[n];
                e_r = a_rd[n] && !ab; e_w = a_wr[n] && !ab;
                if (n == 0) begin
                    e_w0 = s_waitrequest && !ab; e_rd0 = ab ? 32'h0 : s_readdata;
                end else begin
                    e_w1 = s_waitrequest && !ab; e_rd1 = ab ? 32'h0 : s_readdata;
                end
            end
            exp_v = {e_grant, err, e_addr, e_wdata, e_be, e_r, e_w, e_w0, e_rd0, e_w1, e_rd1};
            vecs++;
            if (outs() !== exp_v) begin
                errs++;
                $display("FAIL rand_c%0d got %h exp %h", c, outs(), exp_v);
            end
            if (owner == 0) begin
                if (busy[0] || busy[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick = (busy[0] && busy[1]) ? 1 - last : (busy[0] ? 0 : 1);
`else
                    pick = busy[0] ? 0 : 1;
`endif
                    owner = pick + 1; stalls = 0; last = pick;
                end
            end else if (ab) begin
                err = 1; owner = 0; done[n] = 1;
            end else if (!s_waitrequest) begin
                owner = 0; done[n] = 1;
            end else begin
                stalls++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
